// File: rtl/puf_crp_ctrl.sv
// Challenge/response collection controller for the feed-forward arbiter PUF level.
// Drives LFSR challenges and clear pulses, then packs NBITS sampled responses into one word.
module puf_crp_ctrl #(
    parameter int          NBITS  = 32,
    parameter int          SETTLE = 4,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    output logic [31:0]      C,
    output logic             puf_clr,
    input  logic             puf_r,
    output logic [NBITS-1:0] resp,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int BW = $clog2(NBITS) + 1;
    localparam int SW = $clog2(SETTLE) + 1;
    localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_EVAL   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     lfsr;
    logic [BW-1:0]   bit_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            load_seed;
    logic            accept_start;
    logic            lfsr_fb;

    assign lfsr_fb   = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    assign C         = lfsr;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake: resp_valid is high exactly while in DONE; a word transfers on an edge
    // where resp_valid && resp_ready, and resp is held unchanged until that edge.
    always_comb begin
        state_nxt    = state;
        puf_clr      = 1'b1;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        load_seed    = 1'b0;
        accept_start = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (seed_load) begin
                    load_seed = 1'b1;
                end else if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_EVAL;
            end
            S_EVAL: begin
                puf_clr = 1'b0;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                puf_clr   = 1'b0;
                state_nxt = (bit_cnt == BIT_LAST) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The LFSR only moves in SAMPLE so C stays constant across one bit's clear/eval/sample.
    always_ff @(posedge clk) begin
        if (clr) begin
            lfsr       <= SEED;
            resp       <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (load_seed) begin
                lfsr <= (seed == 32'h0) ? 32'h0000_0001 : seed;
            end else if (state == S_SAMPLE) begin
                lfsr <= {lfsr[30:0], lfsr_fb};
            end

            if (accept_start) begin
                bit_cnt <= '0;
                resp    <= '0;
            end else if (state == S_SAMPLE) begin
                bit_cnt <= bit_cnt + BW'(1);
                resp    <= {resp[NBITS-2:0], puf_r};
            end

            if (state == S_CLEAR) begin
                settle_cnt <= '0;
            end else if (state == S_EVAL) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// Directed bench for puf_crp_ctrl with NBITS=8, SETTLE=4; puf_r comes from a selectable source.
module tb_puf_crp_ctrl;

    localparam int NBITS  = 8;
    localparam int SETTLE = 4;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_EVAL   = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             start = 1'b0;
    logic             seed_load = 1'b0;
    logic [31:0]      seed = 32'h0;
    logic [31:0]      C;
    logic             puf_clr;
    logic             puf_r;
    logic [NBITS-1:0] resp;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             busy;
    logic [2:0]       dbg_state;

    // 0: response tied 0, 1: tied 1, 2: response equals the challenge LSB
    int               r_mode = 2;
    int               errors = 0;
    int               checks = 0;
    int               cycles;
    int               clr_high;
    logic             first_busy;
    logic [31:0]      chal_log[$];
    logic [31:0]      exp_q[$];

    assign puf_r = (r_mode == 2) ? C[0] : (r_mode == 1);

    always #5 clk = ~clk;

    puf_crp_ctrl #(.NBITS(NBITS), .SETTLE(SETTLE), .SEED(32'h0000_0001)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .C          (C),
        .puf_clr    (puf_clr),
        .puf_r      (puf_r),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Tasks start and end just after a falling edge.
    task automatic do_reset();
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // Starts one word and stops at the first falling edge where resp_valid is seen.
    // cycles counts falling edges after the start edge; value k is what edge N+k samples.
    task automatic run_word(input bit disturb);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        clr_high = 0;
        first_busy = 1'b0;
        chal_log.delete();
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) first_busy = busy;
            if (resp_valid) break;
            if (puf_clr) clr_high++;
            if (dbg_state == ST_SAMPLE) chal_log.push_back(C);
            if (disturb) begin
                start      = (cycles % 5 == 2);
                resp_ready = (cycles % 7 == 4);
                seed_load  = (cycles % 11 == 8);
                seed       = 32'h0;
            end
        end
        start = 1'b0;
        resp_ready = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (C !== 32'h1) begin errors++; $display("FAIL reset_c: got %h expected %h", C, 32'h1); end
        if (puf_clr !== 1'b1) begin errors++; $display("FAIL reset_puf_clr: got %b expected 1", puf_clr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp: got %h expected 00", resp); end
        // Abort partway through the second bit's EVAL (edge N+9) with a populated partial word.
        r_mode = 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (dbg_state !== ST_EVAL) begin errors++; $display("FAIL reset_mid_eval_state: got %0d expected %0d", dbg_state, ST_EVAL); end
        do_reset();
        checks += 6;
        if (C !== 32'h1) begin errors++; $display("FAIL clr_c: got %h expected %h", C, 32'h1); end
        if (puf_clr !== 1'b1) begin errors++; $display("FAIL clr_puf_clr: got %b expected 1", puf_clr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", resp_valid); end
        if (resp !== 8'h00) begin errors++; $display("FAIL clr_resp: got %h expected 00", resp); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL clr_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_lfsr_seq();
        r_mode = 2;
        exp_q = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B, 32'h36, 32'h6D, 32'hDB};
        run_word(1'b0);
        checks += 6;
        if (first_busy !== 1'b1) begin errors++; $display("FAIL lfsr_busy_n1: got %b expected 1", first_busy); end
        if (cycles !== 49) begin errors++; $display("FAIL lfsr_latency: got %0d expected 49", cycles); end
        if (resp !== 8'hDB) begin errors++; $display("FAIL lfsr_resp: got %h expected db", resp); end
        if (C !== 32'h1B6) begin errors++; $display("FAIL lfsr_c_after: got %h expected 1b6", C); end
        if (clr_high !== NBITS) begin errors++; $display("FAIL lfsr_clr_pulses: got %0d expected %0d", clr_high, NBITS); end
        if (chal_log.size() !== 8) begin errors++; $display("FAIL lfsr_sample_count: got %0d expected 8", chal_log.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (chal_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL lfsr_chal_%0d: got %h expected %h", i, chal_log[i], exp_q[i]);
            end
        end
        handshake();
    endtask

    task automatic test_constant();
        r_mode = 1;
        run_word(1'b0);
        checks += 3;
        if (resp !== 8'hFF) begin errors++; $display("FAIL const1_resp: got %h expected ff", resp); end
        if (clr_high !== NBITS) begin errors++; $display("FAIL const1_clr_pulses: got %0d expected %0d", clr_high, NBITS); end
        if (cycles !== 49) begin errors++; $display("FAIL const1_latency: got %0d expected 49", cycles); end
        handshake();
        r_mode = 0;
        run_word(1'b0);
        checks += 2;
        if (resp !== 8'h00) begin errors++; $display("FAIL const0_resp: got %h expected 00", resp); end
        if (clr_high !== NBITS) begin errors++; $display("FAIL const0_clr_pulses: got %0d expected %0d", clr_high, NBITS); end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [NBITS-1:0] held_resp;
        logic [31:0]      held_c;
        int               unstable;
        do_reset();
        r_mode = 2;
        run_word(1'b0);
        held_resp = 8'hDB;
        held_c = 32'h1B6;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp !== held_resp || C !== held_c || resp_valid !== 1'b1) unstable++;
            @(negedge clk);
        end
        checks += 3;
        if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        if (resp !== held_resp) begin errors++; $display("FAIL bp_resp: got %h expected %h", resp, held_resp); end
        if (C !== held_c) begin errors++; $display("FAIL bp_c: got %h expected %h", C, held_c); end
        handshake();
        checks += 3;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", resp_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL bp_state_after: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        // Directly follows a handshake: the single IDLE cycle is enough to accept start.
        r_mode = 2;
        run_word(1'b0);
        checks += 3;
        if (cycles !== 49) begin errors++; $display("FAIL b2b_latency: got %0d expected 49", cycles); end
        if (first_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_n1: got %b expected 1", first_busy); end
        if (chal_log.size() > 0 && chal_log[0] !== 32'h1B6) begin
            errors++; $display("FAIL b2b_first_chal: got %h expected 1b6", chal_log[0]);
        end else if (chal_log.size() == 0) begin
            errors++; $display("FAIL b2b_first_chal: got no samples expected 1b6");
        end
        handshake();
    endtask

    task automatic test_seed();
        seed = 32'h0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (C !== 32'h1) begin errors++; $display("FAIL seed_zero: got %h expected 00000001", C); end
        seed = 32'hDEAD_BEEF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (C !== 32'hDEAD_BEEF) begin errors++; $display("FAIL seed_load: got %h expected deadbeef", C); end
        seed = 32'h5;
        seed_load = 1'b1;
        start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        start = 1'b0;
        checks += 3;
        if (C !== 32'h5) begin errors++; $display("FAIL seed_and_start_c: got %h expected 00000005", C); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL seed_and_start_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL seed_and_start_busy: got %b expected 0", busy); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        seed = 32'h1234;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (C !== 32'h5) begin errors++; $display("FAIL seed_while_busy: got %h expected 00000005", C); end
        do_reset();
    endtask

    task automatic test_ignored_controls();
        r_mode = 2;
        exp_q = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B, 32'h36, 32'h6D, 32'hDB};
        run_word(1'b1);
        checks += 3;
        if (resp !== 8'hDB) begin errors++; $display("FAIL ign_resp: got %h expected db", resp); end
        if (cycles !== 49) begin errors++; $display("FAIL ign_latency: got %0d expected 49", cycles); end
        if (chal_log.size() !== 8) begin errors++; $display("FAIL ign_sample_count: got %0d expected 8", chal_log.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (chal_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ign_chal_%0d: got %h expected %h", i, chal_log[i], exp_q[i]);
            end
        end
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (dbg_state !== ST_DONE) begin errors++; $display("FAIL ign_done_state: got %0d expected %0d", dbg_state, ST_DONE); end
        if (resp !== 8'hDB) begin errors++; $display("FAIL ign_done_resp: got %h expected db", resp); end
        // start stays high through the handshake edge and must not begin a new word.
        handshake();
        start = 1'b0;
        checks += 2;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL ign_hs_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_hs_busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_lfsr_seq();
        test_constant();
        test_backpressure();
        test_back_to_back();
        test_seed();
        test_ignored_controls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_crp_ctrl.md
# puf_crp_ctrl

Challenge–response collection controller that sits directly upstream of the feed-forward arbiter PUF level. It generates 32-bit challenges with an LFSR, drives the PUF level's challenge and clear inputs, and waits a programmable settle time. It then samples the single-bit response and packs NBITS consecutive responses into one word, handed downstream with a valid/ready handshake.

## Interface
- NBITS, 32: response bits per output word (2..32).
- SETTLE, 4: cycles the PUF evaluates with clear deasserted before sampling (≥1).
- SEED, 32'h0000_0001: LFSR value after reset (must be nonzero).

- clk  in  1  system clock; all logic rising-edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  begin collecting one word; honoured only in IDLE.
- seed_load  in  1  load `seed` into LFSR; honoured only in IDLE, takes priority over `start`.
- seed  in  32  LFSR load value; 0 is replaced by 32'h0000_0001.
- C  out  32  challenge to PUF level; equals the LFSR register.
- puf_clr  out  1  clear to PUF level (drives its `clr`).
- puf_r  in  1  PUF level response `r`.
- resp  out  NBITS  collected response word.
- resp_valid  out  1  `resp` holds a complete word.
- resp_ready  in  1  downstream accepts word.
- busy  out  1  high in every state except IDLE.

## Operation
- LFSR: 32-bit Fibonacci; advance = {l[30:0], l[31]^l[21]^l[1]^l[0]}. Advances only in SAMPLE. Otherwise holds, so C is stable through each bit's CLEAR/EVAL/SAMPLE.
- FSM states:
  - IDLE: puf_clr=1, busy=0. seed_load → LFSR load, stay IDLE. Else start → CLEAR, with bit counter and `resp` zeroed.
  - CLEAR: puf_clr=1 for 1 cycle → EVAL, settle counter=0.
  - EVAL: puf_clr=0. Settle counter increments; at SETTLE-1 → SAMPLE.
  - SAMPLE: puf_clr=0.
    - resp <= {resp[NBITS-2:0], puf_r}, so the first bit collected ends in the MSB.
    - LFSR advances and the bit counter increments.
    - If the bit counter was NBITS-1 → DONE, else → CLEAR.
  - DONE: puf_clr=1, resp_valid=1, resp held. resp_ready=1 → IDLE with resp_valid=0 next cycle.
- start/seed_load outside IDLE: ignored, no side effects.
- Bit counter width: clog2(NBITS)+1. Settle counter width: clog2(SETTLE)+1. Neither wraps within a word.
- puf_r is treated as already settled at SAMPLE. No synchroniser is in this block, because the PUF level is synchronous to clk.

## Timing
- Reset values: state IDLE, C=SEED, puf_clr=1, resp=0, resp_valid=0, busy=0.
- Cycles per bit: SETTLE+2 (CLEAR 1, EVAL SETTLE, SAMPLE 1).
- Latency:
  - start sampled in IDLE at edge N → resp_valid=1 from edge N+NBITS·(SETTLE+2)+1.
  - busy=1 from edge N+1.
- Backpressure: in DONE, resp, C and the LFSR hold indefinitely until resp_ready. resp_valid never drops without a handshake.
- Handshake edge cases:
  - resp_ready high outside DONE: ignored.
  - start high during the DONE→IDLE handshake cycle: ignored, because the state is not yet IDLE.
- clr mid-operation: next cycle all state and outputs take reset values; LFSR=SEED and the partial word is discarded. clr overrides start, seed_load and resp_ready.
- Back-to-back words: the minimum gap from handshake to the next start acceptance is 1 cycle (IDLE).

## Test plan
- Reset: assert clr for 2 cycles mid-EVAL → C=32'h0000_0001, puf_clr=1, busy=0, resp_valid=0, resp=0 on the cycle after release.
- LFSR sequence: NBITS=8, SETTLE=4, seed 1, puf_r=C[0] modelled.
  - Sampled challenges must be 1,3,6,D,1B,36,6D,DB (hex).
  - Required result: resp=8'hDB, with resp_valid first high 49 cycles after the start edge.
- Constant response: puf_r tied 1 → resp=all ones; tied 0 → resp=0. puf_clr must pulse high exactly one cycle per bit during collection.
- Backpressure: hold resp_ready=0 for 20 cycles in DONE → resp, C and resp_valid stable. Assert resp_ready for 1 cycle → resp_valid=0 and busy=0 next cycle.
- Seed handling:
  - seed_load with seed=0 → C=32'h0000_0001.
  - seed_load+start in the same IDLE cycle → load only, stay IDLE.
  - seed_load while busy → C unchanged.
- Ignored controls: start pulses during EVAL and DONE → no restart, bit count unaffected, final resp identical to an undisturbed run.
